// File: rtl/ru_mem_responder_if.sv
// Request-unit to RAM-responder port: one word read or write per
// transaction, with busy/done handshake and an error flag.
interface ru_mem_responder_if;
   logic        ren;
   logic        wen;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [3:0]  be;
   logic [31:0] data_out;
   logic        busy;
   logic        done;
   logic        err;

   // Request unit side: issues requests, observes completion.
   modport master (
      output ren, wen, addr, data_in, be,
      input  data_out, busy, done, err
   );

   // Memory side: accepts requests, reports completion.
   modport slave (
      input  ren, wen, addr, data_in, be,
      output data_out, busy, done, err
   );
endinterface

// File: rtl/ru_mem_responder.sv
// Memory-side responder for the request unit's RAM port.
// A request seen in IDLE is latched and held for LATENCY busy cycles;
// on the final cycle the array is written (enabled bytes only) or read
// into data_out, and done pulses for one cycle together with err.
// Misaligned or out-of-range accesses complete with the same timing,
// never touch the array, and a faulting read returns zero.
module ru_mem_responder #(
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 2,
   parameter logic [31:0] BASE    = 32'h0000_0000
) (
   input logic               clk,
   input logic               rst,
   ru_mem_responder_if.slave bus
);

   localparam int          AW   = $clog2(DEPTH);
   localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // True when the byte address cannot be served: misaligned, below BASE,
   // or at/after the end of the array. Offset is only meaningful once
   // a >= BASE, so the below-BASE term guards against wrap-around.
   function automatic logic addr_err_f(input logic [31:0] a);
      logic [31:0] off;
      off        = a - BASE;
      addr_err_f = (a[1:0] != 2'b00) || (a < BASE) || ({1'b0, off} >= SPAN);
   endfunction

   logic [31:0]   mem_r [DEPTH];

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic [AW-1:0] word_r;
   logic [31:0]   wdata_r;
   logic [3:0]    be_r;
   logic          write_r;
   logic          aerr_r;
   logic          busy_r;
   logic          done_r;
   logic          err_r;
   logic [31:0]   dout_r;

   logic          req_s;
   logic          aerr_s;
   logic [AW-1:0] word_s;
   logic          complete_s;
   logic          mem_we_s;

   // Decode the incoming request and the completion condition.
   always_comb begin
      req_s      = bus.ren | bus.wen;
      aerr_s     = addr_err_f(bus.addr);
      word_s     = AW'((bus.addr - BASE) >> 2);
      complete_s = (state_r == ST_BUSY) && (cnt_r == {CW{1'b0}});
      mem_we_s   = complete_s && write_r && !aerr_r && !rst;
   end

   // Array write on completion of a valid write; contents are not reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_r[i]) begin
               mem_r[word_r][8*i +: 8] <= wdata_r[8*i +: 8];
            end
         end
      end
   end

   // Transaction FSM: accept in IDLE, count down in BUSY, complete and report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
         word_r  <= {AW{1'b0}};
         wdata_r <= 32'h0000_0000;
         be_r    <= 4'h0;
         write_r <= 1'b0;
         aerr_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         dout_r  <= 32'h0000_0000;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_s) begin
                  word_r  <= word_s;
                  wdata_r <= bus.data_in;
                  be_r    <= bus.be;
                  // Simultaneous read and write resolves to a write.
                  write_r <= bus.wen;
                  aerr_r  <= aerr_s;
                  cnt_r   <= CW'(LATENCY - 1);
                  busy_r  <= 1'b1;
                  state_r <= ST_BUSY;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (cnt_r != {CW{1'b0}}) begin
                  cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  err_r   <= aerr_r;
                  if (!write_r) begin
                     dout_r <= aerr_r ? 32'h0000_0000 : mem_r[word_r];
                  end else begin
                     dout_r <= dout_r;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= {CW{1'b0}};
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out = dout_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.err      = err_r;

endmodule

// File: tb/tb_ru_mem_responder.sv
// Scoreboard bench for ru_mem_responder: stimulus pushes the expected
// completion (from a word/byte array model) into a queue, and a monitor
// pops and compares whenever done is seen.
module tb_ru_mem_responder;
   localparam int          DEPTH   = 1024;
   localparam int          LATENCY = 2;
   localparam logic [31:0] BASE    = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ru_mem_responder_if bus();

   ru_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          is_read;
      bit          err;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem_m [int];
   logic [31:0] last_read = 32'h0;
   int          vectors = 0;
   int          miscompares = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic bit is_bad(logic [31:0] a);
      longint la = longint'(a);
      longint lb = longint'(BASE);
      return (la % 4 != 0) || (la < lb) || (la >= lb + 4 * longint'(DEPTH));
   endfunction

   // Reference model: apply the transaction to the array and queue the
   // completion the DUT must report.
   function automatic void model(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
      exp_t e;
      bit   bad = is_bad(a);
      int   idx = int'((longint'(a) - longint'(BASE)) / 4);
      logic [31:0] word;
      e.is_read = !w;
      e.err     = bad;
      if (w) begin
         if (!bad) begin
            word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int i = 0; i < 4; i++) begin
               if (b[i]) word[8*i +: 8] = d[8*i +: 8];
            end
            mem_m[idx] = word;
         end
         e.data = last_read;
      end else begin
         last_read = bad ? 32'h0 : (mem_m.exists(idx) ? mem_m[idx] : 32'hxxxx_xxxx);
         e.data    = last_read;
      end
      q.push_back(e);
   endfunction

   task automatic garbage();
      bus.ren     = 1'($urandom);
      bus.wen     = 1'($urandom);
      bus.addr    = $urandom;
      bus.data_in = $urandom;
      bus.be      = 4'($urandom);
   endtask

   // Called at a negedge; waits for busy low (scrambling inputs unless
   // hold), presents the request and confirms it was accepted.
   task automatic issue(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b, bit hold);
      int guard = 0;
      while (bus.busy === 1'b1 && guard < 50) begin
         if (!hold) garbage();
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("busy_timeout", 32'd1, 32'd0);
      bus.ren = r; bus.wen = w; bus.addr = a; bus.data_in = d; bus.be = b;
      model(r, w, a, d, b);
      @(posedge clk);
      #1;
      check("accept_busy", {31'b0, bus.busy}, 32'd1);
      @(negedge clk);
   endtask

   task automatic drain();
      int guard = 0;
      while (bus.busy === 1'b1 && guard < 50) begin
         garbage();
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("drain_timeout", 32'd1, 32'd0);
      bus.ren = 1'b0; bus.wen = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 6))
         0, 1, 2: return BASE + 32'(4 * $urandom_range(0, 15));
         3:       return BASE + 32'(4 * (DEPTH - 1 - int'($urandom_range(0, 1))));
         4:       return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
         5:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
         default: return 32'hFFFF_FFFC;
      endcase
   endfunction

   // Monitor: protocol invariants every cycle, scoreboard compare on done.
   int busy_run = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_run = 0;
      end else begin
         if (bus.busy && bus.done) check("busy_done_excl", 32'd1, 32'd0);
         if (bus.err && !bus.done) check("err_without_done", 32'd1, 32'd0);
         if (bus.busy) begin
            busy_run++;
         end else begin
            if (busy_run != 0) check("busy_len", 32'(busy_run), 32'(LATENCY));
            busy_run = 0;
         end
         if (bus.done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("err", {31'b0, bus.err}, {31'b0, e.err});
               check(e.is_read ? "rdata" : "data_hold", bus.data_out, e.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = 32'h0; bus.data_in = 32'h0; bus.be = 4'h0;

      // Asynchronous reset observed before any clock edge.
      #1 rst = 1'b1;
      #1;
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_err",  {31'b0, bus.err},  32'd0);
      check("rst_data", bus.data_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Fill the words the random phase will read.
      for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 1'b0);
      issue(1'b0, 1'b1, BASE + 32'(4 * (DEPTH - 2)), $urandom, 4'hF, 1'b0);
      issue(1'b0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), $urandom, 4'hF, 1'b0);

      // Full write then read back.
      issue(1'b0, 1'b1, 32'h10, 32'hCAFE_BABE, 4'hF, 1'b0);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      drain();
      check("cafebabe", bus.data_out, 32'hCAFE_BABE);

      // Partial write: bytes 0 and 2 replaced.
      issue(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0);
      issue(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
      drain();
      check("partial", bus.data_out, 32'h11BB_33DD);

      // Error cases: misaligned, one past the end, misaligned write.
      issue(1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
      drain();
      check("err_rd_zero", bus.data_out, 32'h0);
      issue(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 1'b0);
      issue(1'b0, 1'b1, 32'h13, 32'hDEAD_BEEF, 4'hF, 1'b0);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

      // Request held high across done: back-to-back reads.
      issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

      // Read and write together act as a write.
      issue(1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 1'b0);
      issue(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
      drain();
      check("ren_wen_write", bus.data_out, 32'h0BAD_F00D);

      // Randomised traffic.
      for (int n = 0; n < 200; n++) begin
         bit w = 1'($urandom);
         issue(!w || ($urandom_range(0, 7) == 0), w, pick_addr(), $urandom, 4'($urandom),
               ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 4) == 0) drain();
      end
      drain();

      // Reset in the middle of a write: aborted, no done, old data kept.
      bus.ren = 1'b0; bus.wen = 1'b1; bus.addr = 32'h30; bus.data_in = 32'h5; bus.be = 4'hF;
      @(posedge clk);
      #3 rst = 1'b1;
      bus.wen = 1'b0;
      #1;
      check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
      check("mid_rst_done", {31'b0, bus.done}, 32'd0);
      check("mid_rst_err",  {31'b0, bus.err},  32'd0);
      check("mid_rst_data", bus.data_out, 32'd0);
      last_read = 32'h0;
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      issue(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
      drain();
      drain();

      check("queue_empty", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
